// File: rtl/alu_pkg.sv
// Shared types for the handshaked sequential ALU: opcodes, FSM states and flag layout.
// Flag types are only consumed when ALU_FLAGS_EN is defined.
package alu_pkg;

  localparam int OpcodeWidth = 4;

  // Existing encodings are frozen; new operations are appended at the end.
  typedef enum logic [OpcodeWidth-1:0] {
    kAddition          = 4'd0,
    kSubtraction       = 4'd1,
    kBinaryAnd         = 4'd2,
    kBinaryOr          = 4'd3,
    kBinaryXor         = 4'd4,
    kShiftLeftLogical  = 4'd5,
    kShiftRightLogical = 4'd6,
    kShiftRightArith   = 4'd7,
    kLessThanSigned    = 4'd8,
    kLessThanUnsigned  = 4'd9,
    kMultiply          = 4'd10
  } opcode_e;

  typedef enum logic [1:0] {
    kIdle    = 2'd0,
    kMulBusy = 2'd1,
    kHold    = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic negative;
    logic zero;
    logic carry;
    logic overflow;
  } alu_flags_t;

  function automatic logic isMultiCycle(input opcode_e op);
    return op == kMultiply;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier retiring MulRadixBits multiplier bits per cycle.
// done is asserted during the final iteration; product is valid in that same cycle.
module alu_mul_iter #(
  parameter int DataWidth    = 32,
  parameter int MulRadixBits = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DataWidth-1:0] operandA,
  input  logic [DataWidth-1:0] operandB,
  output logic                 done,
  output logic [DataWidth-1:0] product
);

  localparam int K    = DataWidth / MulRadixBits;
  localparam int CntW = (K > 1) ? $clog2(K) : 1;

  logic [DataWidth-1:0] mcandReg;
  logic [DataWidth-1:0] mplierReg;
  logic [DataWidth-1:0] accReg;
  logic [DataWidth-1:0] accNext;
  logic [DataWidth-1:0] partial;
  logic [CntW-1:0]      countReg;
  logic                 runningReg;
  logic                 lastIter;

  logic [DataWidth-1:0] terms [MulRadixBits];

  // One shifted copy of the multiplicand per multiplier bit of the current digit.
  genvar gi;
  generate
    for (gi = 0; gi < MulRadixBits; gi++) begin : gTerm
      assign terms[gi] = mplierReg[gi] ? (mcandReg << gi) : '0;
    end
  endgenerate

  always_comb begin
    partial = '0;
    for (int i = 0; i < MulRadixBits; i++) begin
      partial = partial + terms[i];
    end
  end

  assign accNext  = accReg + partial;
  assign lastIter = (countReg == CntW'(K - 1));
  assign done     = runningReg && lastIter;
  assign product  = accNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcandReg   <= '0;
      mplierReg  <= '0;
      accReg     <= '0;
      countReg   <= '0;
      runningReg <= 1'b0;
    end else if (start) begin
      mcandReg   <= operandA;
      mplierReg  <= operandB;
      accReg     <= '0;
      countReg   <= '0;
      runningReg <= 1'b1;
    end else if (runningReg) begin
      accReg    <= accNext;
      mcandReg  <= mcandReg << MulRadixBits;
      mplierReg <= mplierReg >> MulRadixBits;
      if (lastIter) begin
        countReg   <= '0;
        runningReg <= 1'b0;
      end else begin
        countReg <= countReg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops return one cycle after accept, kMultiply iterates K cycles.
// Define ALU_FLAGS_EN to add the registered flags[3:0] = {negative, zero, carry, overflow} port.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int MulRadixBits = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [DataWidth-1:0] operandA,
  input  logic [DataWidth-1:0] operandB,
  input  opcode_e              opcode,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [DataWidth-1:0] result,
  output logic                 busy
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]           flags
`endif
);

  localparam int ShiftW = $clog2(DataWidth);

  alu_state_e           state;
  logic                 accept;
  logic                 mulStart;
  logic                 mulDone;
  logic [DataWidth-1:0] mulProduct;
  logic [DataWidth-1:0] aluResult;
  logic [ShiftW-1:0]    shamt;

  // inReady must never depend on inValid, so the producer can't form a loop through us.
  assign inReady  = (state == kIdle) || ((state == kHold) && outReady);
  assign accept   = inValid && inReady;
  assign mulStart = accept && isMultiCycle(opcode);
  assign shamt    = operandB[ShiftW-1:0];

  always_comb begin
    aluResult = '0;
    case (opcode)
      kAddition:          aluResult = operandA + operandB;
      kSubtraction:       aluResult = operandA - operandB;
      kBinaryAnd:         aluResult = operandA & operandB;
      kBinaryOr:          aluResult = operandA | operandB;
      kBinaryXor:         aluResult = operandA ^ operandB;
      kShiftLeftLogical:  aluResult = operandA << shamt;
      kShiftRightLogical: aluResult = operandA >> shamt;
      kShiftRightArith:   aluResult = $signed(operandA) >>> shamt;
      kLessThanSigned:    aluResult = {{(DataWidth-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
      kLessThanUnsigned:  aluResult = {{(DataWidth-1){1'b0}}, (operandA < operandB)};
      default:            aluResult = '0;
    endcase
  end

  alu_mul_iter #(
    .DataWidth   (DataWidth),
    .MulRadixBits(MulRadixBits)
  ) uMul (
    .clk     (clk),
    .rst     (rst),
    .start   (mulStart),
    .operandA(operandA),
    .operandB(operandB),
    .done    (mulDone),
    .product (mulProduct)
  );

`ifdef ALU_FLAGS_EN
  logic [DataWidth:0] addFull;
  logic [DataWidth:0] subFull;
  alu_flags_t         aluFlags;
  alu_flags_t         mulFlags;
  alu_flags_t         flagsReg;

  // Subtraction as a + ~b + 1 so the carry-out is directly the borrow-not.
  always_comb begin
    addFull           = {1'b0, operandA} + {1'b0, operandB};
    subFull           = {1'b0, operandA} + {1'b0, ~operandB} + {{DataWidth{1'b0}}, 1'b1};
    aluFlags.negative = aluResult[DataWidth-1];
    aluFlags.zero     = (aluResult == '0);
    aluFlags.carry    = 1'b0;
    aluFlags.overflow = 1'b0;
    if (opcode == kAddition) begin
      aluFlags.carry    = addFull[DataWidth];
      aluFlags.overflow = (operandA[DataWidth-1] == operandB[DataWidth-1]) &&
                          (addFull[DataWidth-1] != operandA[DataWidth-1]);
    end else if (opcode == kSubtraction) begin
      aluFlags.carry    = subFull[DataWidth];
      aluFlags.overflow = (operandA[DataWidth-1] != operandB[DataWidth-1]) &&
                          (subFull[DataWidth-1] != operandA[DataWidth-1]);
    end
  end

  always_comb begin
    mulFlags.negative = mulProduct[DataWidth-1];
    mulFlags.zero     = (mulProduct == '0);
    mulFlags.carry    = 1'b0;
    mulFlags.overflow = 1'b0;
  end

  assign flags = flagsReg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= kIdle;
      outValid <= 1'b0;
      result   <= '0;
      busy     <= 1'b0;
`ifdef ALU_FLAGS_EN
      flagsReg <= '0;
`endif
    end else if (accept) begin
      // Reached from kIdle or from kHold with outReady, which gives back-to-back issue.
      if (isMultiCycle(opcode)) begin
        state    <= kMulBusy;
        outValid <= 1'b0;
        busy     <= 1'b1;
      end else begin
        state    <= kHold;
        outValid <= 1'b1;
        result   <= aluResult;
        busy     <= 1'b0;
`ifdef ALU_FLAGS_EN
        flagsReg <= aluFlags;
`endif
      end
    end else begin
      case (state)
        kMulBusy: begin
          if (mulDone) begin
            state    <= kHold;
            outValid <= 1'b1;
            result   <= mulProduct;
            busy     <= 1'b0;
`ifdef ALU_FLAGS_EN
            flagsReg <= mulFlags;
`endif
          end
        end
        kHold: begin
          if (outReady) begin
            state    <= kIdle;
            outValid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table for single-cycle ops plus multi-cycle sequences.
// A second instance with MulRadixBits=4 shares the inputs to check the shorter multiply.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inValid;
  logic        outReady;
  logic [31:0] operandA;
  logic [31:0] operandB;
  opcode_e     opcode;
  logic        inReady,  outValid,  busy;
  logic        inReady4, outValid4, busy4;
  logic [31:0] result, result4;
`ifdef ALU_FLAGS_EN
  logic [3:0]  flags, flags4;
`endif

  int passCount  = 0;
  int totalCount = 0;

  always #5 clk = ~clk;

  alu_seq #(.DataWidth(32), .MulRadixBits(1)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
    .operandA(operandA), .operandB(operandB), .opcode(opcode),
    .outValid(outValid), .outReady(outReady), .result(result), .busy(busy)
`ifdef ALU_FLAGS_EN
    , .flags(flags)
`endif
  );

  alu_seq #(.DataWidth(32), .MulRadixBits(4)) dut4 (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady4),
    .operandA(operandA), .operandB(operandB), .opcode(opcode),
    .outValid(outValid4), .outReady(outReady), .result(result4), .busy(busy4)
`ifdef ALU_FLAGS_EN
    , .flags(flags4)
`endif
  );

  typedef struct {
    opcode_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) begin
      passCount++;
      $display("check %s: got %h expected %h ok", name, act, exp);
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called one step after a rising edge with both instances idle; returns the same way.
  task automatic applyVec(input string name, input vec_t v);
    opcode   = v.op;
    operandA = v.a;
    operandB = v.b;
    inValid  = 1'b1;
    outReady = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    check({name, "_valid"}, {31'd0, outValid}, 32'd1);
    check({name, "_result"}, result, v.res);
    check({name, "_result4"}, result4, v.res);
`ifdef ALU_FLAGS_EN
    check({name, "_flags"}, {28'd0, flags}, {28'd0, v.fl});
`endif
    @(posedge clk); #1;
  endtask

  // Multiply on both instances; optionally hold an add on inValid throughout the busy phase.
  task automatic mulCheck(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit holdNext);
    int   n1, n4;
    bit   done1, done4, busyOk;
    logic [31:0] res1, res4;
    opcode   = kMultiply;
    operandA = a;
    operandB = b;
    inValid  = 1'b1;
    outReady = 1'b1;
    @(posedge clk); #1;
    if (holdNext) begin
      opcode   = kAddition;
      operandA = 32'd3;
      operandB = 32'd4;
    end else begin
      inValid = 1'b0;
    end
    n1 = -1; n4 = -1; done1 = 0; done4 = 0; busyOk = 1;
    res1 = '0; res4 = '0;
    for (int c = 0; c < 100 && !(done1 && done4); c++) begin
      if (!done1) begin
        if (outValid) begin
          done1 = 1; n1 = c; res1 = result;
        end else if (!busy || inReady) begin
          busyOk = 0;
        end
      end
      if (!done4 && outValid4) begin
        done4 = 1; n4 = c; res4 = result4;
      end
      if (!(done1 && done4)) begin
        @(posedge clk); #1;
      end
    end
    check({name, "_latency"}, n1, 32'd32);
    check({name, "_latency4"}, n4, 32'd8);
    check({name, "_product"}, res1, exp);
    check({name, "_product4"}, res4, exp);
    check({name, "_busy"}, {31'd0, busyOk}, 32'd1);
    @(posedge clk); #1;
    if (holdNext) begin
      inValid = 1'b0;
      check({name, "_held_op"}, result, 32'd7);
      check({name, "_held_valid"}, {31'd0, outValid}, 32'd1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bit seen;

    vecs[0]  = '{kAddition,          32'd3,         32'd4,         32'd7,         4'b0000};
    vecs[1]  = '{kAddition,          32'hFFFFFFFF,  32'd1,         32'h00000000,  4'b0110};
    vecs[2]  = '{kSubtraction,       32'd0,         32'd1,         32'hFFFFFFFF,  4'b1000};
    vecs[3]  = '{kBinaryXor,         32'hF0F0F0F0,  32'hFFFF0000,  32'h0F0FF0F0,  4'b0000};
    vecs[4]  = '{kBinaryAnd,         32'hF0F0F0F0,  32'hFFFF0000,  32'hF0F00000,  4'b1000};
    vecs[5]  = '{kBinaryOr,          32'h0F0F0000,  32'h000000FF,  32'h0F0F00FF,  4'b0000};
    vecs[6]  = '{kShiftRightArith,   32'h80000000,  32'd4,         32'hF8000000,  4'b1000};
    vecs[7]  = '{kShiftRightLogical, 32'h80000000,  32'd4,         32'h08000000,  4'b0000};
    vecs[8]  = '{kShiftLeftLogical,  32'h00000001,  32'd31,        32'h80000000,  4'b1000};
    vecs[9]  = '{kShiftRightLogical, 32'h12345678,  32'd0,         32'h12345678,  4'b0000};
    vecs[10] = '{kShiftLeftLogical,  32'h00000001,  32'h00000021,  32'h00000002,  4'b0000};
    vecs[11] = '{kLessThanSigned,    32'h80000000,  32'd1,         32'd1,         4'b0000};
    vecs[12] = '{kLessThanUnsigned,  32'h80000000,  32'd1,         32'd0,         4'b0100};
    vecs[13] = '{kAddition,          32'h7FFFFFFF,  32'd1,         32'h80000000,  4'b1001};
    vecs[14] = '{kSubtraction,       32'd5,         32'd5,         32'd0,         4'b0110};
    vecs[15] = '{opcode_e'(4'hF),    32'd5,         32'd3,         32'd0,         4'b0100};

    rst = 1'b1; inValid = 1'b0; outReady = 1'b0;
    operandA = '0; operandB = '0; opcode = kAddition;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outValid", {31'd0, outValid}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_inReady", {31'd0, inReady}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      applyVec($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-to-back: second op accepted on the same edge the first result is consumed.
    opcode = kAddition; operandA = 32'hFFFFFFFF; operandB = 32'd1;
    inValid = 1'b1; outReady = 1'b1;
    @(posedge clk); #1;
    check("b2b_first", result, 32'h00000000);
    check("b2b_inReady", {31'd0, inReady}, 32'd1);
    opcode = kSubtraction; operandA = 32'd0; operandB = 32'd1;
    @(posedge clk); #1;
    inValid = 1'b0;
    check("b2b_second", result, 32'hFFFFFFFF);
    check("b2b_second_valid", {31'd0, outValid}, 32'd1);
    @(posedge clk); #1;
    check("b2b_drain", {31'd0, outValid}, 32'd0);

    // Backpressure: result held while outReady stays low.
    opcode = kBinaryXor; operandA = 32'hF0F0F0F0; operandB = 32'hFFFF0000;
    inValid = 1'b1; outReady = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("bp_hold%0d_result", c), result, 32'h0F0FF0F0);
      check($sformatf("bp_hold%0d_valid", c), {31'd0, outValid}, 32'd1);
      check($sformatf("bp_hold%0d_inReady", c), {31'd0, inReady}, 32'd0);
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", {31'd0, outValid}, 32'd0);
    check("bp_release_inReady", {31'd0, inReady}, 32'd1);

    // Multiplies, including multiply by zero and a held op during kMulBusy.
    mulCheck("mul_basic", 32'h00010001, 32'h00010001, 32'h00020001, 1'b0);
    mulCheck("mul_zero",  32'h00000000, 32'h00000005, 32'h00000000, 1'b0);
    mulCheck("mul_neg",   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    mulCheck("mul_hold",  32'h12345678, 32'h00000009, 32'hA3D70A38, 1'b1);

    // Reset in kHold drops outValid asynchronously.
    opcode = kBinaryXor; operandA = 32'hF0F0F0F0; operandB = 32'hFFFF0000;
    inValid = 1'b1; outReady = 1'b0;
    @(posedge clk); #1;
    inValid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_hold_valid", {31'd0, outValid}, 32'd0);
    check("rst_hold_result", result, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rst_hold_inReady", {31'd0, inReady}, 32'd1);

    // Reset mid-multiply at cycle 5: no result may ever appear.
    opcode = kMultiply; operandA = 32'h00010001; operandB = 32'h00010001;
    inValid = 1'b1; outReady = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mul_busy", {31'd0, busy}, 32'd0);
    check("rst_mul_valid", {31'd0, outValid}, 32'd0);
    #3 rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (outValid || outValid4) seen = 1;
    end
    check("rst_mul_no_output", {31'd0, seen}, 32'd0);
    check("rst_mul_inReady", {31'd0, inReady}, 32'd1);
    applyVec("post_reset_add", vecs[0]);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Handshaked, parametrised successor to the combinational ALU.
- Accepts one operation per valid/ready transfer and returns a registered result through a valid/ready output.
- Adds a multi-cycle iterative multiply (kMultiply); all existing opcodes stay single-cycle.
- Sits between the decode/issue stage and writeback; backpressure from writeback stalls the block.

Parameters:
- DataWidth, 32, operand/result width; must be ≥ 2.
- MulRadixBits, 1, multiplier bits retired per iteration; must divide DataWidth.
- MulCycles, DataWidth/MulRadixBits, derived localparam K; not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- inValid  input  1  operation presented.
- inReady  output  1  block can accept an operation this cycle.
- operandA  input  DataWidth  first operand.
- operandB  input  DataWidth  second operand; shift amount is operandB[$clog2(DataWidth)-1:0].
- opcode  input  opcode_e  operation select.
- outValid  output  1  result available.
- outReady  input  1  consumer accepts the result.
- result  output  DataWidth  registered result.
- busy  output  1  high while in kMulBusy.

Behaviour:
- Reset (asynchronous, active-high): state=kIdle, outValid=0, result=0, busy=0, iteration count=0. In-flight work is dropped with no output.
- inReady = (state==kIdle) || (state==kHold && outReady). It is combinational from state and outReady only, never from inValid.
- Accept = inValid && inReady. Operands and opcode are sampled only on an accept edge.
- FSM:
  - kIdle: on accept of a single-cycle op, register the result, set outValid, go to kHold. On accept of kMultiply, latch the operands, clear the accumulator, count=0, go to kMulBusy.
  - kMulBusy: inReady=0, busy=1. Each cycle add (multiplicand × MulRadixBits multiplier bits) and increment count. On the edge where count reaches K-1, write the low DataWidth product bits to result, set outValid, go to kHold.
  - kHold: outValid=1, and result stays stable until the output handshake completes.
    - outReady=0: hold.
    - outReady=1 and no accept: clear outValid, go to kIdle.
    - outReady=1 and accept: handled exactly as an accept in kIdle, same edge (back-to-back).
- Latency, counted from the accept edge to outValid visible:
  - single-cycle ops: 1 cycle, throughput 1 op/cycle under continuous outReady.
  - kMultiply: K cycles, issue interval K+1 at best.
- Arithmetic:
  - add/sub wrap modulo 2^DataWidth.
  - kShiftRightArith uses the signed view of operandA.
  - Comparisons return a zero-extended 1 or 0. Signed variants compare two's-complement values.
  - kMultiply returns the low DataWidth bits of the product; these are identical for signed and unsigned operands.
  - An unenumerated opcode value produces result 0 with normal handshake timing.
- Boundaries:
  - Shift by 0 returns operandA.
  - Shift amount DataWidth-1 is legal; higher bits of operandB are ignored.
  - Multiply by 0 still takes K cycles.
  - inValid during kMulBusy is ignored and the operation is not lost; the producer must hold it.
  - outReady during kIdle or kMulBusy has no effect.
  - Reset asserted in kMulBusy or kHold deasserts outValid immediately, asynchronously.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined: adds output port flags[3:0] = {negative, zero, carry, overflow}.
  - Registered with result and stable under the same hold rules; reset value 0.
  - carry/overflow are meaningful only for kAddition/kSubtraction (carry = borrow-not for subtraction); they are 0 for other ops.
  - negative = result[DataWidth-1]; zero = (result==0).
- Not defined: no flags port and no flag logic; all other behaviour is identical.

Decomposition:
- alu_pkg:
  - opcode_e extended with kMultiply appended; existing encodings unchanged.
  - alu_state_e {kIdle, kMulBusy, kHold}.
  - alu_flags_t packed struct, used under ALU_FLAGS_EN.
- Sub-module alu_mul_iter: iterative shift-add multiplier.
  - Ports: start, operands, done, product.
  - Parameters: DataWidth, MulRadixBits.
  - alu_seq owns the FSM and the single-cycle datapath.

Test Plan:
- Reset: assert rst mid-multiply at cycle 5 → outValid=0, inReady=1 after deassert, no result emitted. Then 3+4 → result 7 one cycle after accept.
- Back-to-back: outReady=1, kAddition 0xFFFFFFFF+1 then kSubtraction 0-1 on consecutive cycles → results 0x00000000, 0xFFFFFFFF on consecutive cycles, inReady stays 1.
- Backpressure: kBinaryXor 0xF0F0F0F0^0xFFFF0000 with outReady=0 for 4 cycles → result 0x0F0FF0F0 held stable, inReady=0, then released on the outReady edge.
- Multiply (DataWidth=32, MulRadixBits=1): 0x00010001×0x00010001 → 0x00020001 exactly 32 cycles after accept, busy=1 throughout. Repeat with MulRadixBits=4 → 8 cycles.
- Shifts/compares: kShiftRightArith 0x80000000>>>4 → 0xF8000000; kShiftRightLogical → 0x08000000; kLessThanSigned 0x80000000<1 → 1; kLessThanUnsigned → 0.
- ALU_FLAGS_EN: 0x7FFFFFFF+1 → flags 4'b1001 (negative, overflow); 5-5 → 4'b0110 (zero, carry).
